ram_dp_clear: RTL and testbench
===============================

# ram_dp_clear

Parametrised simple-dual-port synchronous RAM: one write port and one read port in the same clock domain, with a built-in clear sequencer. After reset, or on request, the sequencer fills every word with a constant. A `busy` flag blocks user traffic while the fill runs, and a `rd_valid` strobe marks returned data. This block replaces the fixed 256x8 single-port buffer used by the UART demos. It is the general storage block for line buffers, TX/RX staging and small lookup tables.

## Interface
- `DATA_W`, default 8: word width in bits, legal range 1–64.
- `ADDR_W`, default 8: address width; depth = 2^ADDR_W words.
- `CLEAR_VALUE`, default 0: value (DATA_W bits) written by the clear sequencer.
- `RDW_MODE`, default 0: same-address read-during-write behaviour. 0 = old data, 1 = new data (write-through).
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: write request.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input DATA_W: write data.
- `rd_en` input 1: read request.
- `rd_addr` input ADDR_W: read address.
- `rd_data` output DATA_W: registered read data.
- `rd_valid` output 1: one-cycle strobe; `rd_data` is valid while it is high.
- `clear_req` input 1: single-cycle pulse that starts a full clear.
- `busy` output 1: high while the clear sequencer owns the array.

## Operation
- **States:** the FSM has two states, CLEAR and IDLE, plus a counter `clr_addr` of ADDR_W bits.
- **Reset:** when `rst` is sampled high, the block sets state to CLEAR, `clr_addr` to 0, `rd_data` to 0 and `rd_valid` to 0.
- **CLEAR state:** each cycle writes CLEAR_VALUE to `mem[clr_addr]` and increments `clr_addr`.
  - When the write of address 2^ADDR_W−1 completes, the state goes to IDLE and `clr_addr` wraps to 0.
- **Requests during CLEAR:** `wr_en`, `rd_en` and `clear_req` are ignored. No write is performed, `rd_valid` stays 0 and `rd_data` holds its value.
- **`busy`:** equals (state == CLEAR) and is driven directly from the state register.
- **IDLE, write:** `wr_en` writes `wr_data` to `mem[wr_addr]`.
- **IDLE, read:** `rd_en` loads `rd_data` from `mem[rd_addr]` and sets `rd_valid` high for the next cycle.
  - `rd_valid` is 0 in any cycle that follows one without an accepted read.
  - `rd_data` holds its last value when no read is accepted.
- **Simultaneous read and write, different addresses:** both are performed independently.
- **Simultaneous read and write, same address:**
  - RDW_MODE=0: `rd_data` returns the pre-write contents.
  - RDW_MODE=1: `rd_data` returns `wr_data`.
- **`clear_req` in IDLE:** any user read or write in the same cycle is still performed. CLEAR starts on the next edge.
- **`rst` during CLEAR:** the sequence restarts from address 0.
- **`rst` and `clear_req` together:** reset has priority; the result is identical to reset alone.
- **Address range:** addresses are taken modulo 2^ADDR_W; every address is in range.

## Timing
- **Read latency:** 1 cycle from an accepted `rd_en` to `rd_data`/`rd_valid`. Throughput is one read and one write per cycle.
- **Write visibility:** a write in cycle N is visible to a read of the same address issued in cycle N+1 in both RDW modes.
- **Clear duration:** exactly 2^ADDR_W cycles.
  - After reset: `busy` is high for 2^ADDR_W cycles counted from the first edge after `rst` falls. The first user request is accepted in the cycle `busy` is first sampled low.
  - After `clear_req` at edge N: `busy` is high for edges N+1 … N+2^ADDR_W.
- **Reset values:** `rd_data`=0, `rd_valid`=0, `busy`=1 from the first edge with `rst` high.

## Structure
- Shared package `ram_pkg`:
  - RDW mode constants `RDW_OLD`=0 and `RDW_NEW`=1.
  - State enum {CLEAR, IDLE}.
- Sub-module `ram_sdp_core`: a pure storage array with one write port and one registered read port, no reset, structured so it infers block RAM.
- `ram_dp_clear` owns:
  - the FSM;
  - the counter;
  - the mux that selects the write port source (user or sequencer);
  - the RDW bypass register;
  - `rd_valid`.
- Bench configuration: DATA_W=8, ADDR_W=4 (depth 16), CLEAR_VALUE=8'hA5, unless a scenario says otherwise.

## Test plan
- **Reset clear:** pulse `rst`, then hold `rd_en`=1 and `rd_addr`=3 throughout.
  - `busy` is high for exactly 16 cycles and `rd_valid` stays 0 during that time.
  - The first read returns 8'hA5 with `rd_valid`=1 one cycle later.
- **Write then read:** write 8'h3C to address 7, then read address 7 on the next cycle.
  - `rd_data`=8'h3C with `rd_valid`=1 one cycle after the read.
  - Addresses 0–6 and 8–15 still return 8'hA5.
- **Collision:** address 2 holds 8'h11; issue a write of 8'h22 and a read, both to address 2, in the same cycle.
  - RDW_MODE=0: the read returns 8'h11.
  - RDW_MODE=1: the read returns 8'h22.
  - In both modes, a read of address 2 on the following cycle returns 8'h22.
- **Requested clear:** fill all 16 words with their own address value, pulse `clear_req`, then issue a write of 8'hFF to address 5 during `busy`.
  - `busy` is high for 16 cycles.
  - Afterwards all 16 addresses read 8'hA5, proving the write to address 5 was ignored.
- **Reset mid-clear:** assert `rst` when `clr_addr`=9.
  - `busy` remains high for a full 16 cycles after `rst` falls.
  - All words read 8'hA5 afterwards.
- **Back-to-back streaming:** read addresses 0–15 consecutively with `rd_en` held high, and 0x10+addr written to each address the cycle before it is read.
  - `rd_valid` is high on 16 consecutive cycles.
  - `rd_data` returns 0x10–0x1F in order.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port RAM with clear sequencer.
package ram_pkg;

    // Same-address read-during-write behaviour.
    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Sequencer states: StClear owns the array, StIdle serves user traffic.
    typedef enum logic [0:0] {
        StClear,
        StIdle
    } state_e;

    // Where the registered read data currently comes from.
    typedef enum logic [1:0] {
        SrcZero,
        SrcCore,
        SrcByp
    } rd_src_e;

endpackage

// File: rtl/ram_sdp_core.sv
// Plain storage array: one write port, one registered read port, no reset.
// Read-first behaviour on same-address collisions (returns old contents).
module ram_sdp_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [Depth];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value when re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_dp_clear.sv
// Simple-dual-port RAM with a built-in clear sequencer that fills every word
// with CLEAR_VALUE after reset or on request. busy blocks user traffic.
module ram_dp_clear
    import ram_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       ADDR_W      = 8,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0,
    parameter int unsigned       RDW_MODE    = RDW_OLD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clear_req,
    output logic              busy
);

    state_e            state_q;
    logic [ADDR_W-1:0] clr_addr_q;

    rd_src_e           rd_src_q;
    logic [DATA_W-1:0] byp_q;
    logic              rd_valid_q;

    logic              wr_acc;
    logic              rd_acc;
    logic              bypass;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] core_rdata;

    assign busy = (state_q == StClear);

    // User requests are only accepted in IDLE; a cycle with rst high accepts nothing.
    assign wr_acc = wr_en && !busy && !rst;
    assign rd_acc = rd_en && !busy && !rst;

    // Write-through only matters when both ports hit the same word in one cycle.
    assign bypass = (RDW_MODE == RDW_NEW) && wr_acc && rd_acc && (wr_addr == rd_addr);

    // Sequencer FSM and clear address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            unique case (state_q)
                StClear: begin
                    clr_addr_q <= clr_addr_q + ADDR_W'(1);
                    if (&clr_addr_q) begin
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (clear_req) begin
                        state_q <= StClear;
                    end
                end
                default: begin
                    state_q    <= StClear;
                    clr_addr_q <= '0;
                end
            endcase
        end
    end

    // Write port source: the sequencer while busy, otherwise the user port.
    always_comb begin
        mem_we    = wr_acc;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = CLEAR_VALUE;
        end
    end

    ram_sdp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_acc),
        .raddr (rd_addr),
        .rdata (core_rdata)
    );

    // Read strobe, read-source select and write-through bypass register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_src_q   <= SrcZero;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rd_src_q <= bypass ? SrcByp : SrcCore;
            end
        end
    end

    // Bypass data carries no reset; it is only selected after a bypassed read.
    always_ff @(posedge clk) begin
        if (bypass) begin
            byp_q <= wr_data;
        end
    end

    // Output mux; SrcZero gives the reset value before the first accepted read.
    always_comb begin
        rd_data = '0;
        unique case (rd_src_q)
            SrcCore: rd_data = core_rdata;
            SrcByp:  rd_data = byp_q;
            default: rd_data = '0;
        endcase
    end

    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_dp_clear.sv
// Directed bench for ram_dp_clear: one instance per RDW mode, shared stimulus.
module tb_ram_dp_clear;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam logic [7:0]  CV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          clear_req;

    logic [DW-1:0] rd_data_old, rd_data_new;
    logic          rd_valid_old, rd_valid_new;
    logic          busy_old, busy_new;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_dp_clear #(
        .DATA_W (DW), .ADDR_W (AW), .CLEAR_VALUE (CV), .RDW_MODE (0)
    ) dut_old (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data_old), .rd_valid (rd_valid_old),
        .clear_req (clear_req), .busy (busy_old)
    );

    ram_dp_clear #(
        .DATA_W (DW), .ADDR_W (AW), .CLEAR_VALUE (CV), .RDW_MODE (1)
    ) dut_new (
        .clk (clk), .rst (rst), .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data_new), .rd_valid (rd_valid_new),
        .clear_req (clear_req), .busy (busy_new)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic          ev;
        logic [DW-1:0] eo;
        logic [DW-1:0] en;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic re, input logic [AW-1:0] ra, input logic ev,
                                input logic [DW-1:0] eo, input logic [DW-1:0] en);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.ev = ev; v.eo = eo; v.en = en;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic ev, input logic [DW-1:0] eo,
                           input logic [DW-1:0] en);
        chk({name, " valid(old)"}, 64'(rd_valid_old), 64'(ev));
        chk({name, " valid(new)"}, 64'(rd_valid_new), 64'(ev));
        chk({name, " data(old)"}, 64'(rd_data_old), 64'(eo));
        chk({name, " data(new)"}, 64'(rd_data_new), 64'(en));
    endtask

    // Counts busy samples (start already seen) until both drop; bounded.
    task automatic run_busy(input string name, input int start);
        int n_old = start;
        int n_new = start;
        int guard = 0;
        step();
        while ((busy_old || busy_new) && guard < 40) begin
            if (busy_old) n_old++;
            if (busy_new) n_new++;
            chk({name, " valid low while busy(old)"}, 64'(rd_valid_old), 64'd0);
            chk({name, " valid low while busy(new)"}, 64'(rd_valid_new), 64'd0);
            step();
            guard++;
        end
        chk({name, " busy cycles(old)"}, 64'(n_old), 64'd16);
        chk({name, " busy cycles(new)"}, 64'(n_new), 64'd16);
        chk({name, " valid low at busy fall(old)"}, 64'(rd_valid_old), 64'd0);
        chk({name, " valid low at busy fall(new)"}, 64'(rd_valid_new), 64'd0);
    endtask

    task automatic fill_own_addr();
        for (int a = 0; a < 16; a++) begin
            wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(a);
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic read_all_clear(input string name);
        for (int a = 0; a < 16; a++) begin
            rd_en = 1'b1; rd_addr = AW'(a);
            step();
            chk_out(name, 1'b1, CV, CV);
        end
        rd_en = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b1; rd_addr = 4'd3; clear_req = 1'b0;

        // Reset clear with a read held on address 3 throughout.
        step();
        chk("reset busy(old)", 64'(busy_old), 64'd1);
        chk("reset busy(new)", 64'(busy_new), 64'd1);
        chk_out("reset", 1'b0, 8'h00, 8'h00);
        rst = 1'b0;
        run_busy("reset clear", 1);
        step();
        chk_out("first read", 1'b1, CV, CV);
        rd_en = 1'b0;

        // Table-driven: write/read, untouched words, collision, independent ports.
        tbl.push_back(mk(1, 4'd7, 8'h3C, 0, 4'd0, 0, CV, CV));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd7, 1, 8'h3C, 8'h3C));
        for (int a = 0; a < 16; a++) begin
            if (a != 7) tbl.push_back(mk(0, 4'd0, 8'h00, 1, AW'(a), 1, CV, CV));
        end
        tbl.push_back(mk(1, 4'd2, 8'h11, 0, 4'd0, 0, CV, CV));
        tbl.push_back(mk(1, 4'd2, 8'h22, 1, 4'd2, 1, 8'h11, 8'h22));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd2, 1, 8'h22, 8'h22));
        tbl.push_back(mk(1, 4'd9, 8'h77, 1, 4'd7, 1, 8'h3C, 8'h3C));
        tbl.push_back(mk(0, 4'd0, 8'h00, 1, 4'd9, 1, 8'h77, 8'h77));
        tbl.push_back(mk(0, 4'd0, 8'h00, 0, 4'd0, 0, 8'h77, 8'h77));
        for (int i = 0; i < tbl.size(); i++) begin
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            rd_en = tbl[i].re; rd_addr = tbl[i].ra;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].eo, tbl[i].en);
        end
        wr_en = 1'b0; rd_en = 1'b0;

        // Requested clear; a read in the request cycle is still served,
        // a write to address 5 during busy must be dropped.
        fill_own_addr();
        clear_req = 1'b1; rd_en = 1'b1; rd_addr = 4'd5;
        step();
        chk("clear_req busy(old)", 64'(busy_old), 64'd1);
        chk("clear_req busy(new)", 64'(busy_new), 64'd1);
        chk_out("read in clear_req cycle", 1'b1, 8'h05, 8'h05);
        clear_req = 1'b0;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hFF;
        run_busy("requested clear", 1);
        wr_en = 1'b0; rd_en = 1'b0;
        read_all_clear("after requested clear");

        // Reset (together with clear_req) when the sequencer is at address 9.
        fill_own_addr();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (9) step();
        rst = 1'b1; clear_req = 1'b1;
        step();
        chk("mid-clear rst busy(old)", 64'(busy_old), 64'd1);
        chk("mid-clear rst busy(new)", 64'(busy_new), 64'd1);
        chk_out("mid-clear rst", 1'b0, 8'h00, 8'h00);
        rst = 1'b0; clear_req = 1'b0;
        run_busy("reset mid-clear", 1);
        read_all_clear("after reset mid-clear");

        // Streaming: write 0x10+a in cycle a, read a in cycle a+1.
        for (int c = 0; c <= 16; c++) begin
            wr_en = (c < 16); wr_addr = AW'(c); wr_data = DW'(8'h10 + c);
            rd_en = (c >= 1); rd_addr = AW'(c - 1);
            step();
            if (c >= 1) chk_out($sformatf("stream%0d", c - 1), 1'b1, DW'(8'h10 + c - 1),
                                DW'(8'h10 + c - 1));
        end
        wr_en = 1'b0; rd_en = 1'b0;
        step();
        chk_out("stream end", 1'b0, 8'h1F, 8'h1F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
